// File: rtl/bpf_axilite_ctrl.sv
// AXI4-Lite control/status slave for the packet filter: loads 64-bit instructions
// as two 32-bit halves, drives run control and counts accepted packets.
module bpf_axilite_ctrl #(
   parameter int ADDR_W      = 5,
   parameter int INST_ADDR_W = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      s_axi_awaddr,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [31:0]            s_axi_wdata,
   input  logic [3:0]             s_axi_wstrb,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [ADDR_W-1:0]      s_axi_araddr,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [31:0]            s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   output logic [INST_ADDR_W-1:0] inst_wr_addr,
   output logic [63:0]            inst_wr_data,
   output logic                   inst_wr_en,
   output logic                   running,
   input  logic                   pkt_accept
);
   localparam int PTR_W = INST_ADDR_W + 1;

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CTRL     = 3'd1;
   localparam logic [2:0] REG_INST_LO  = 3'd2;
   localparam logic [2:0] REG_INST_HI  = 3'd3;
   localparam logic [2:0] REG_ACCEPT   = 3'd4;
   localparam logic [2:0] REG_INST_PTR = 3'd5;

   logic                   r_aw_done, r_w_done, r_bvalid, r_rvalid;
   logic                   r_running, r_overflow, r_inst_wr_en;
   logic [2:0]             r_aw_sel;
   logic [31:0]            r_wdata, r_hi, r_cnt, r_rdata;
   logic [1:0]             r_bresp;
   logic [PTR_W-1:0]       r_ptr;
   logic [INST_ADDR_W-1:0] r_inst_addr;
   logic [63:0]            r_inst_data;

   logic        w_aw_hs, w_w_hs, w_ar_hs, w_do_wr;
   logic        w_err, w_commit, w_set_ovf, w_load_hi, w_ptr_clr, w_start, w_stop;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   // Ready lines are gated by rst so they read 0 while reset is held.
   assign s_axi_awready = !rst && !r_aw_done && !r_bvalid;
   assign s_axi_wready  = !rst && !r_w_done && !r_bvalid;
   assign s_axi_arready = !rst && !r_rvalid;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = 2'b00;
   assign inst_wr_en    = r_inst_wr_en;
   assign inst_wr_addr  = r_inst_addr;
   assign inst_wr_data  = r_inst_data;
   assign running       = r_running;

   assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_w_hs   = s_axi_wvalid && s_axi_wready;
   assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
   assign w_do_wr  = r_aw_done && r_w_done && !r_bvalid;
   assign w_unused = ^{s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

   // Bit INST_ADDR_W of the pointer marks a completely filled memory.
   always_comb begin
      w_err     = 1'b0;
      w_commit  = 1'b0;
      w_set_ovf = 1'b0;
      w_load_hi = 1'b0;
      w_ptr_clr = 1'b0;
      w_start   = 1'b0;
      w_stop    = 1'b0;
      if (w_do_wr) begin
         case (r_aw_sel)
            REG_CTRL: begin
               w_start = r_wdata[0];
               w_stop  = r_wdata[1];
            end
            REG_INST_LO: begin
               if (r_running) begin
                  w_err = 1'b1;
               end else if (r_ptr[INST_ADDR_W]) begin
                  w_err     = 1'b1;
                  w_set_ovf = 1'b1;
               end else begin
                  w_commit = 1'b1;
               end
            end
            REG_INST_HI:  if (r_running) w_err = 1'b1; else w_load_hi = 1'b1;
            REG_INST_PTR: if (r_running) w_err = 1'b1; else w_ptr_clr = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rd_mux = 32'd0;
      case (s_axi_araddr[4:2])
         REG_STATUS:   w_rd_mux = {30'd0, r_overflow, r_running};
         REG_INST_HI:  w_rd_mux = r_hi;
         REG_ACCEPT:   w_rd_mux = r_cnt;
         REG_INST_PTR: w_rd_mux = 32'(r_ptr);
         default:      w_rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_aw_sel  <= 3'd0;
         r_wdata   <= 32'd0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         if (w_aw_hs) begin
            r_aw_done <= 1'b1;
            r_aw_sel  <= s_axi_awaddr[4:2];
         end
         if (w_w_hs) begin
            r_w_done <= 1'b1;
            r_wdata  <= s_axi_wdata;
         end
         if (w_do_wr) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_err ? 2'b10 : 2'b00;
         end else if (r_bvalid && s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst_wr_en <= 1'b0;
         r_inst_addr  <= '0;
         r_inst_data  <= 64'd0;
         r_ptr        <= '0;
         r_overflow   <= 1'b0;
         r_hi         <= 32'd0;
         r_running    <= 1'b0;
         r_cnt        <= 32'd0;
      end else begin
         r_inst_wr_en <= w_commit;
         if (w_commit) begin
            r_inst_addr <= r_ptr[INST_ADDR_W-1:0];
            r_inst_data <= {r_hi, r_wdata};
            r_ptr       <= r_ptr + PTR_W'(1);
         end else if (w_ptr_clr) begin
            r_ptr <= '0;
         end
         if (w_ptr_clr)      r_overflow <= 1'b0;
         else if (w_set_ovf) r_overflow <= 1'b1;
         if (w_load_hi) r_hi <= r_wdata;
         if (w_stop)       r_running <= 1'b0;
         else if (w_start) r_running <= 1'b1;
         // A start clears the count even when a packet is accepted that cycle.
         if (w_start)         r_cnt <= 32'd0;
         else if (pkt_accept) r_cnt <= r_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'd0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_mux;
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bpf_axilite_ctrl.sv
// Scoreboard bench for bpf_axilite_ctrl: directed scenarios plus random register
// traffic checked against an abstract register-map model.
module tb_bpf_axilite_ctrl;
   localparam int ADDR_W  = 5;
   localparam int INST_AW = 4;
   localparam int DEPTH   = 1 << INST_AW;
   localparam int TMO     = 50;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [ADDR_W-1:0]  s_axi_awaddr = '0;
   logic               s_axi_awvalid = 1'b0;
   logic               s_axi_awready;
   logic [31:0]        s_axi_wdata = '0;
   logic [3:0]         s_axi_wstrb = 4'hF;
   logic               s_axi_wvalid = 1'b0;
   logic               s_axi_wready;
   logic [1:0]         s_axi_bresp;
   logic               s_axi_bvalid;
   logic               s_axi_bready = 1'b0;
   logic [ADDR_W-1:0]  s_axi_araddr = '0;
   logic               s_axi_arvalid = 1'b0;
   logic               s_axi_arready;
   logic [31:0]        s_axi_rdata;
   logic [1:0]         s_axi_rresp;
   logic               s_axi_rvalid;
   logic               s_axi_rready = 1'b0;
   logic [INST_AW-1:0] inst_wr_addr;
   logic [63:0]        inst_wr_data;
   logic               inst_wr_en;
   logic               running;
   logic               pkt_accept = 1'b0;

   always #5 clk = ~clk;

   bpf_axilite_ctrl #(.ADDR_W(ADDR_W), .INST_ADDR_W(INST_AW)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .inst_wr_addr(inst_wr_addr), .inst_wr_data(inst_wr_data), .inst_wr_en(inst_wr_en),
      .running(running), .pkt_accept(pkt_accept)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [1:0]          exp_b_q[$];
   logic [31:0]         exp_r_q[$];
   logic [INST_AW+63:0] exp_i_q[$];

   // Register-map model
   bit          m_running, m_ovf;
   int unsigned m_ptr;
   logic [31:0] m_hi, m_cnt;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out after %0d cycles, expected a handshake", nm, TMO);
   endtask

   function automatic void model_reset();
      m_running = 0; m_ovf = 0; m_ptr = 0; m_hi = 0; m_cnt = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a[4:2])
         3'd0:    return {30'd0, m_ovf, m_running};
         3'd3:    return m_hi;
         3'd4:    return m_cnt;
         3'd5:    return 32'(m_ptr);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d);
      case (a[4:2])
         3'd1: begin
            if (d[0]) m_cnt = 0;
            if (d[1]) m_running = 0;
            else if (d[0]) m_running = 1;
            return 2'b00;
         end
         3'd2: begin
            if (m_running) return 2'b10;
            if (m_ptr == DEPTH) begin
               m_ovf = 1;
               return 2'b10;
            end
            exp_i_q.push_back({INST_AW'(m_ptr), m_hi, d});
            m_ptr++;
            return 2'b00;
         end
         3'd3: begin
            if (m_running) return 2'b10;
            m_hi = d;
            return 2'b00;
         end
         3'd5: begin
            if (m_running) return 2'b10;
            m_ptr = 0;
            m_ovf = 0;
            return 2'b00;
         end
         default: return 2'b00;
      endcase
   endfunction

   // Monitor: pops expectations whenever the DUT presents a response or strobe.
   always @(negedge clk) begin
      if (!rst) begin
         if (s_axi_bvalid && s_axi_bready) begin
            if (exp_b_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL b_unexpected: got resp %0d, expected no response", s_axi_bresp);
            end else begin
               $display("B   resp=%0d", s_axi_bresp);
               chk("bresp", 96'(s_axi_bresp), 96'(exp_b_q.pop_front()));
            end
         end
         if (s_axi_rvalid && s_axi_rready) begin
            if (exp_r_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL r_unexpected: got data 0x%0h, expected no response", s_axi_rdata);
            end else begin
               $display("R   data=0x%08h", s_axi_rdata);
               chk("rdata", 96'(s_axi_rdata), 96'(exp_r_q.pop_front()));
               chk("rresp", 96'(s_axi_rresp), 96'd0);
            end
         end
         if (inst_wr_en) begin
            if (exp_i_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL inst_unexpected: got strobe at addr %0d, expected none", inst_wr_addr);
            end else begin
               $display("IW  addr=%0d data=0x%016h", inst_wr_addr, inst_wr_data);
               chk("inst_wr", 96'({inst_wr_addr, inst_wr_data}), 96'(exp_i_q.pop_front()));
               chk("inst_wr_with_bvalid", 96'(s_axi_bvalid), 96'd1);
            end
         end
      end
   end

   task automatic wait_hs(input int ch, output bit ok);
      bit r;
      int t = 0;
      do begin
         @(negedge clk);
         case (ch)
            0:       r = s_axi_awready;
            1:       r = s_axi_wready;
            default: r = s_axi_arready;
         endcase
         t++;
         @(posedge clk); #1;
      end while (!r && t < TMO);
      ok = r;
   endtask

   task automatic write_issue(input logic [4:0] a, input logic [31:0] d, input int lead);
      @(posedge clk); #1;
      fork
         begin
            bit ok;
            for (int i = 0; i < -lead; i++) begin @(posedge clk); #1; end
            s_axi_awaddr = a; s_axi_awvalid = 1'b1;
            wait_hs(0, ok);
            s_axi_awvalid = 1'b0;
            if (!ok) timeout("aw_handshake");
         end
         begin
            bit ok;
            for (int i = 0; i < lead; i++) begin @(posedge clk); #1; end
            s_axi_wdata = d; s_axi_wvalid = 1'b1;
            wait_hs(1, ok);
            s_axi_wvalid = 1'b0;
            if (!ok) timeout("w_handshake");
         end
      join
   endtask

   task automatic wait_bvalid(output bit seen);
      seen = 0;
      for (int t = 0; t < TMO && !seen; t++) begin
         @(negedge clk);
         seen = s_axi_bvalid;
      end
   endtask

   task automatic write_resp(input int bdly, input bit acc_on_commit);
      bit seen;
      if (acc_on_commit) begin
         pkt_accept = 1'b1;
         @(posedge clk); #1;
         pkt_accept = 1'b0;
      end
      wait_bvalid(seen);
      if (!seen) begin
         timeout("bvalid");
         return;
      end
      for (int i = 0; i < bdly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bvalid_hold", 96'(s_axi_bvalid), 96'd1);
         chk("awready_hold", 96'(s_axi_awready), 96'd0);
         chk("wready_hold", 96'(s_axi_wready), 96'd0);
      end
      @(posedge clk); #1 s_axi_bready = 1'b1;
      @(posedge clk); #1 s_axi_bready = 1'b0;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input int lead, input int bdly);
      exp_b_q.push_back(model_write(a, d));
      write_issue(a, d, lead);
      write_resp(bdly, 1'b0);
   endtask

   task automatic axi_read(input logic [4:0] a, input int rdly, input bit acc);
      bit ok, seen;
      logic [31:0] first;
      exp_r_q.push_back(model_read(a));
      @(posedge clk); #1;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      if (acc) begin
         pkt_accept = 1'b1;
         m_cnt++;
      end
      wait_hs(2, ok);
      s_axi_arvalid = 1'b0;
      pkt_accept = 1'b0;
      if (!ok) begin
         timeout("ar_handshake");
         return;
      end
      seen = 0;
      for (int t = 0; t < TMO && !seen; t++) begin
         @(negedge clk);
         seen = s_axi_rvalid;
      end
      if (!seen) begin
         timeout("rvalid");
         return;
      end
      first = s_axi_rdata;
      for (int i = 0; i < rdly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("rvalid_hold", 96'(s_axi_rvalid), 96'd1);
         chk("rdata_hold", 96'(s_axi_rdata), 96'(first));
      end
      @(posedge clk); #1 s_axi_rready = 1'b1;
      @(posedge clk); #1 s_axi_rready = 1'b0;
   endtask

   task automatic pulse_accept(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 pkt_accept = 1'b1;
         m_cnt++;
         @(posedge clk); #1 pkt_accept = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, op, lead, dly;
      logic [4:0] ra;
      logic [31:0] rd;
      bit seen;

      model_reset();
      #12;
      chk("rst_awready", 96'(s_axi_awready), 96'd0);
      chk("rst_wready", 96'(s_axi_wready), 96'd0);
      chk("rst_bvalid", 96'(s_axi_bvalid), 96'd0);
      chk("rst_bresp", 96'(s_axi_bresp), 96'd0);
      chk("rst_arready", 96'(s_axi_arready), 96'd0);
      chk("rst_rvalid", 96'(s_axi_rvalid), 96'd0);
      chk("rst_rdata", 96'(s_axi_rdata), 96'd0);
      chk("rst_rresp", 96'(s_axi_rresp), 96'd0);
      chk("rst_inst_wr_en", 96'(inst_wr_en), 96'd0);
      chk("rst_inst_wr_addr", 96'(inst_wr_addr), 96'd0);
      chk("rst_inst_wr_data", 96'(inst_wr_data), 96'd0);
      chk("rst_running", 96'(running), 96'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Program a full memory, AW leading W by 3 cycles on odd writes
      k = 0;
      for (int i = 0; i < DEPTH; i++) begin
         axi_write(5'h0C, $urandom, (k % 2 == 1) ? 3 : 0, 0); k++;
         axi_write(5'h08, $urandom, (k % 2 == 1) ? 3 : 0, 0); k++;
      end
      axi_read(5'h14, 0, 0);
      axi_read(5'h0C, 0, 0);

      // Write past the end, then rewind the pointer
      axi_write(5'h08, $urandom, 0, 0);
      axi_read(5'h00, 0, 0);
      axi_write(5'h14, $urandom, 0, 0);
      axi_read(5'h00, 0, 0);
      axi_read(5'h14, 0, 0);

      // Writes rejected while running
      axi_write(5'h04, 32'h1, 0, 0);
      axi_write(5'h08, $urandom, 0, 0);
      axi_read(5'h00, 0, 0);
      axi_write(5'h0C, $urandom, -2, 0);
      axi_write(5'h14, 32'h0, 2, 0);
      axi_write(5'h04, 32'h2, 0, 0);
      axi_read(5'h00, 0, 0);
      axi_write(5'h04, 32'h3, 0, 0);
      axi_read(5'h00, 0, 0);

      // Accept counter, read-during-increment, restart coinciding with an accept
      axi_write(5'h04, 32'h1, 0, 0);
      pulse_accept(7);
      axi_read(5'h10, 0, 0);
      axi_read(5'h10, 0, 1);
      axi_read(5'h10, 0, 0);
      exp_b_q.push_back(model_write(5'h04, 32'h1));
      write_issue(5'h04, 32'h1, 0);
      write_resp(0, 1'b1);
      axi_read(5'h10, 0, 0);
      axi_write(5'h04, 32'h2, 0, 0);

      // Backpressure on B and R, unmapped addresses
      axi_write(5'h0C, 32'hA5A5_5A5A, 0, 10);
      axi_read(5'h0C, 10, 0);
      axi_read(5'h18, 0, 0);
      axi_write(5'h18, 32'hFFFF_FFFF, 0, 0);
      axi_read(5'h04, 0, 0);
      axi_read(5'h08, 0, 0);

      // Random register traffic
      for (int n = 0; n < 300; n++) begin
         op   = int'($urandom_range(0, 6));
         lead = int'($urandom_range(0, 6)) - 3;
         dly  = int'($urandom_range(0, 3));
         ra   = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         case (op)
            0: axi_write(ra, $urandom, lead, dly);
            1: axi_read(ra, dly, 1'($urandom_range(0, 1)));
            2: pulse_accept(int'($urandom_range(1, 4)));
            3: axi_write(5'h04, 32'($urandom_range(0, 3)), lead, dly);
            4: axi_write(5'h08, $urandom, lead, dly);
            5: axi_write(5'h0C, $urandom, lead, dly);
            default: axi_write(5'h14, $urandom, lead, dly);
         endcase
      end

      // Asynchronous reset while a write response is pending
      axi_write(5'h04, 32'h2, 0, 0);
      axi_write(5'h14, 32'h0, 0, 0);
      axi_write(5'h0C, 32'h1234_5678, 0, 0);
      axi_write(5'h08, 32'h9ABC_DEF0, 0, 0);
      axi_write(5'h04, 32'h1, 0, 0);
      pulse_accept(3);
      exp_b_q.push_back(model_write(5'h04, 32'h0));
      write_issue(5'h04, 32'h0, 0);
      wait_bvalid(seen);
      if (!seen) timeout("bvalid_before_reset");
      #2 rst = 1'b1;
      #1;
      chk("arst_bvalid", 96'(s_axi_bvalid), 96'd0);
      chk("arst_running", 96'(running), 96'd0);
      chk("arst_awready", 96'(s_axi_awready), 96'd0);
      chk("arst_inst_wr_addr", 96'(inst_wr_addr), 96'd0);
      exp_b_q.delete();
      model_reset();
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      axi_read(5'h14, 0, 0);
      axi_read(5'h10, 0, 0);
      axi_read(5'h00, 0, 0);
      axi_read(5'h0C, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("b_queue_drained", 96'(exp_b_q.size()), 96'd0);
      chk("r_queue_drained", 96'(exp_r_q.size()), 96'd0);
      chk("inst_queue_drained", 96'(exp_i_q.size()), 96'd0);
      rd = 32'(n_vec);
      $display("== %0d vectors applied, %0d miscompares ==", rd, n_err);
      $finish;
   end
endmodule
